// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings,
// controller state enum, byte-enable constants and lane helper functions.
package dm_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } dm_state_e;

    // Misaligned halves/words and the reserved size code are rejected.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables for the addressed lane(s) within the word.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = BE_BYTE << lo;
            SZ_HALF: be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_WORD: be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

    // Right-justified store data replicated across every lane so the RAM
    // only needs the byte enables to place it.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{wdata[7:0]}};
            SZ_HALF: wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load-data lane selection with zero or sign extension.
module dm_lane_ext
    import dm_arbiter_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half out of the full RAM word.
    always_comb begin
        byte_s = rdata[7:0];
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane; the fill bit is the lane MSB unless unsigned.
    always_comb begin
        ext = rdata;
        case (size)
            SZ_BYTE: ext = {{24{~is_unsigned & byte_s[7]}}, byte_s};
            SZ_HALF: ext = {{16{~is_unsigned & half_s[15]}}, half_s};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory access controller: round-robin arbitration between the CPU
// and DMA ports, fixed-latency RAM sequencing, and extended load return.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [1:0]  dma_size,
    input  logic        dma_unsigned,
    input  logic [31:0] dma_wdata,
    output logic        dma_done,
    output logic        dma_err,
    output logic [31:0] dma_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // The counter only has to hold MEM_LATENCY-1.
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    dm_state_e state_q, state_d;
    logic             prio_dma_q, prio_dma_d;   // 1: DMA wins a tie
    logic             gnt_dma_q, gnt_dma_d;     // owner of the transaction
    logic             we_q, we_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_done_q, cpu_done_d, cpu_err_q, cpu_err_d;
    logic             dma_done_q, dma_done_d, dma_err_q, dma_err_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic             mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;

    logic             gnt_dma_s;
    logic             sel_we_s;
    logic [31:0]      sel_addr_s;
    logic [1:0]       sel_size_s;
    logic             sel_uns_s;
    logic [31:0]      sel_wdata_s;
    logic [31:0]      ext_s;

    dm_lane_ext u_lane_ext (
        .rdata       (mem_rdata),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext         (ext_s)
    );

    // Round-robin winner and the request fields of the winning port.
    always_comb begin
        if (cpu_req && dma_req) begin
            gnt_dma_s = prio_dma_q;
        end else if (dma_req) begin
            gnt_dma_s = 1'b1;
        end else begin
            gnt_dma_s = 1'b0;
        end
        if (gnt_dma_s) begin
            sel_we_s    = dma_we;
            sel_addr_s  = dma_addr;
            sel_size_s  = dma_size;
            sel_uns_s   = dma_unsigned;
            sel_wdata_s = dma_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_size_s  = cpu_size;
            sel_uns_s   = cpu_unsigned;
            sel_wdata_s = cpu_wdata;
        end
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        prio_dma_d  = prio_dma_q;
        gnt_dma_d   = gnt_dma_q;
        we_d        = we_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        cnt_d       = cnt_q;
        cpu_done_d  = 1'b0;
        cpu_err_d   = 1'b0;
        dma_done_d  = 1'b0;
        dma_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    gnt_dma_d  = gnt_dma_s;
                    prio_dma_d = ~gnt_dma_s;
                    we_d       = sel_we_s;
                    addr_lo_d  = sel_addr_s[1:0];
                    size_d     = sel_size_s;
                    uns_d      = sel_uns_s;
                    if (access_bad(sel_size_s, sel_addr_s[1:0])) begin
                        // Rejected: report at once, the RAM is never touched.
                        state_d    = ST_ERR;
                        cpu_done_d = ~gnt_dma_s;
                        cpu_err_d  = ~gnt_dma_s;
                        dma_done_d = gnt_dma_s;
                        dma_err_d  = gnt_dma_s;
                    end else begin
                        // Strobe fields are registered so they appear in ISSUE.
                        state_d     = ST_ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we_s;
                        mem_addr_d  = {sel_addr_s[31:2], 2'b00};
                        mem_be_d    = byte_enables(sel_size_s, sel_addr_s[1:0]);
                        mem_wdata_d = lane_wdata(sel_size_s, sel_wdata_s);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    // mem_rdata is valid in this cycle only.
                    state_d    = ST_DONE;
                    cpu_done_d = ~gnt_dma_q;
                    dma_done_d = gnt_dma_q;
                    if (!we_q && !gnt_dma_q) begin
                        cpu_rdata_d = ext_s;
                    end else if (!we_q && gnt_dma_q) begin
                        dma_rdata_d = ext_s;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prio_dma_q  <= 1'b0;
            gnt_dma_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_lo_q   <= 2'b00;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            cnt_q       <= CNT_ZERO;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_done_q  <= 1'b0;
            dma_err_q   <= 1'b0;
            cpu_rdata_q <= 32'h0000_0000;
            dma_rdata_q <= 32'h0000_0000;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            prio_dma_q  <= prio_dma_d;
            gnt_dma_q   <= gnt_dma_d;
            we_q        <= we_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            cnt_q       <= cnt_d;
            cpu_done_q  <= cpu_done_d;
            cpu_err_q   <= cpu_err_d;
            dma_done_q  <= dma_done_d;
            dma_err_q   <= dma_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_done  = cpu_done_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_done  = dma_done_q;
    assign dma_err   = dma_err_q;
    assign dma_rdata = dma_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: three instances (MEM_LATENCY 2, 1, 4),
// each with a fixed-latency RAM model driving garbage outside the valid cycle.
module tb_dm_arbiter;

    typedef struct {
        int          inst;
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        int          inst;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } mexp_t;

    exp_t  exp_q[$];
    mexp_t mexp_q[$];

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    bit stall_chk = 1'b0;

    logic clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] cpu_req, cpu_we, cpu_unsigned, cpu_done, cpu_err, cpu_stall;
    logic [2:0] dma_req, dma_we, dma_unsigned, dma_done, dma_err;
    logic [2:0][31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
    logic [2:0][1:0]  cpu_size, dma_size;
    logic [2:0] mem_en, mem_we;
    logic [2:0][31:0] mem_addr, mem_wdata;
    logic [2:0][3:0]  mem_be;
    logic [31:0] ret_data [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic [7:0]  en_hist = 8'h00;
        logic [31:0] rdata_s;
        always @(posedge clk) en_hist <= {en_hist[6:0], mem_en[g]};
        assign rdata_s = en_hist[LAT-1] ? ret_data[g] : 32'hDEAD_BEEF;

        dm_arbiter #(.MEM_LATENCY(LAT)) u_dut (
            .clk(clk), .reset(rst[g]),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_size(cpu_size[g]), .cpu_unsigned(cpu_unsigned[g]), .cpu_wdata(cpu_wdata[g]),
            .cpu_done(cpu_done[g]), .cpu_err(cpu_err[g]), .cpu_rdata(cpu_rdata[g]),
            .cpu_stall(cpu_stall[g]),
            .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
            .dma_size(dma_size[g]), .dma_unsigned(dma_unsigned[g]), .dma_wdata(dma_wdata[g]),
            .dma_done(dma_done[g]), .dma_err(dma_err[g]), .dma_rdata(dma_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_be(mem_be[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(rdata_s)
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int g);
        nvec++;
        nfail++;
        $display("FAIL %s: inst %0d cycle %0d", name, g, cyc);
    endtask

    // Monitor: pops expectations whenever a DUT presents mem_en or a done pulse.
    always @(negedge clk) begin
        mexp_t m;
        exp_t  e;
        bit    exp_cpu0;
        exp_cpu0 = (exp_q.size() > 0) && (exp_q[0].inst == 0) &&
                   (exp_q[0].port == 1'b0) && (exp_q[0].cyc == cyc);
        if (stall_chk && cpu_req[0]) check("cpu_stall", {31'd0, cpu_stall[0]}, {31'd0, ~exp_cpu0});
        for (int g = 0; g < 3; g++) begin
            if (mem_en[g]) begin
                if (mexp_q.size() == 0 || mexp_q[0].inst != g) begin
                    flag("unexpected_mem_en", g);
                end else begin
                    m = mexp_q.pop_front();
                    check("mem_en_cycle", cyc, m.cyc);
                    check("mem_we", {31'd0, mem_we[g]}, {31'd0, m.we});
                    check("mem_addr", mem_addr[g], m.addr);
                    check("mem_be", {28'd0, mem_be[g]}, {28'd0, m.be});
                    if (m.we) check("mem_wdata", mem_wdata[g], m.wdata);
                end
            end
            for (int p = 0; p < 2; p++) begin
                logic        dn, er;
                logic [31:0] rd;
                dn = (p == 1) ? dma_done[g]  : cpu_done[g];
                er = (p == 1) ? dma_err[g]   : cpu_err[g];
                rd = (p == 1) ? dma_rdata[g] : cpu_rdata[g];
                if (dn) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != g || exp_q[0].port != p[0]) begin
                        flag(p == 1 ? "unexpected_dma_done" : "unexpected_cpu_done", g);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("done_err", {31'd0, er}, {31'd0, e.err});
                        check("rdata", rd, e.rdata);
                    end
                end else if (er) begin
                    flag("err_without_done", g);
                end
            end
        end
    end

    // One complete request from an idle DUT; returns in the following IDLE cycle.
    task automatic do_req(input int g, input bit dma, input bit we, input logic [31:0] addr,
                          input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                          input logic [31:0] ret, input bit exp_err, input logic [31:0] exp_rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        exp_t  e;
        mexp_t m;
        bit    got;
        int    c;
        c = cyc;
        ret_data[g] = ret;
        if (dma) begin
            dma_we[g] = we; dma_addr[g] = addr; dma_size[g] = size;
            dma_unsigned[g] = uns; dma_wdata[g] = wdata; dma_req[g] = 1'b1;
        end else begin
            cpu_we[g] = we; cpu_addr[g] = addr; cpu_size[g] = size;
            cpu_unsigned[g] = uns; cpu_wdata[g] = wdata; cpu_req[g] = 1'b1;
        end
        e.inst = g; e.port = dma; e.err = exp_err; e.rdata = exp_rdata;
        e.cyc = exp_err ? c + 1 : c + 2 + lat_of(g);
        exp_q.push_back(e);
        if (!exp_err) begin
            m.inst = g; m.we = we; m.addr = {addr[31:2], 2'b00};
            m.be = exp_be; m.wdata = exp_wdata; m.cyc = c + 1;
            mexp_q.push_back(m);
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (dma ? dma_done[g] : cpu_done[g]) got = 1'b1;
        end
        #1;
        cpu_req[g] = 1'b0;
        dma_req[g] = 1'b0;
        if (!got) flag("done_timeout", g);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero(input int g);
        check("rst_pulses", {26'd0, mem_en[g], mem_we[g], cpu_done[g], cpu_err[g],
                             dma_done[g], dma_err[g]}, 32'h0000_0000);
        check("rst_mem_addr", mem_addr[g], 32'h0000_0000);
        check("rst_mem_be", {28'd0, mem_be[g]}, 32'h0000_0000);
        check("rst_mem_wdata", mem_wdata[g], 32'h0000_0000);
        check("rst_cpu_rdata", cpu_rdata[g], 32'h0000_0000);
        check("rst_dma_rdata", dma_rdata[g], 32'h0000_0000);
    endtask

    // Start a load, reset the DUT while it waits on the RAM, confirm silence.
    task automatic abort_in_wait(input int g);
        mexp_t m;
        cpu_we[g] = 1'b0; cpu_addr[g] = 32'h0000_0500; cpu_size[g] = 2'b10;
        cpu_unsigned[g] = 1'b0; cpu_req[g] = 1'b1; ret_data[g] = 32'h55AA_55AA;
        m.inst = g; m.we = 1'b0; m.addr = 32'h0000_0500; m.be = 4'b1111;
        m.wdata = 32'h0; m.cyc = cyc + 1;
        mexp_q.push_back(m);
        repeat (2) @(negedge clk);
        #1;
        rst[g] = 1'b1;
        cpu_req[g] = 1'b0;
        @(negedge clk);
        #1;
        chk_zero(g);
        rst[g] = 1'b0;
        repeat (8) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t  e;
        mexp_t m;
        int    c;
        rst = 3'b111;
        cpu_req = '0; cpu_we = '0; cpu_unsigned = '0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0;
        dma_req = '0; dma_we = '0; dma_unsigned = '0; dma_addr = '0; dma_wdata = '0; dma_size = '0;
        for (int g = 0; g < 3; g++) ret_data[g] = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        rst = 3'b000;
        for (int g = 0; g < 3; g++) chk_zero(g);

        // Both ports request continuously from reset: CPU, DMA, CPU.
        stall_chk = 1'b1;
        c = cyc;
        ret_data[0] = 32'h0000_0042;
        cpu_addr[0] = 32'h0000_0300; cpu_size[0] = 2'b10; cpu_we[0] = 1'b0;
        dma_addr[0] = 32'h0000_0400; dma_size[0] = 2'b10; dma_we[0] = 1'b0;
        cpu_req[0] = 1'b1; dma_req[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.inst = 0; e.port = (i == 1); e.err = 1'b0; e.rdata = 32'h0000_0042;
            e.cyc = c + 4 + 5 * i;
            exp_q.push_back(e);
            m.inst = 0; m.we = 1'b0; m.addr = (i == 1) ? 32'h0000_0400 : 32'h0000_0300;
            m.be = 4'b1111; m.wdata = 32'h0; m.cyc = c + 1 + 5 * i;
            mexp_q.push_back(m);
        end
        repeat (14) @(negedge clk);
        #1;
        cpu_req[0] = 1'b0; dma_req[0] = 1'b0;
        stall_chk = 1'b0;
        @(negedge clk);
        #1;

        // g dma we addr size uns wdata ret err exp_rdata be mem_wdata
        do_req(0, 0, 0, 32'h0000_0100, 2'b10, 0, 32'h0, 32'h8899_AABB, 0, 32'h8899_AABB, 4'b1111, 32'h0);
        do_req(0, 0, 0, 32'h0000_0103, 2'b00, 0, 32'h0, 32'h80FF_FFFF, 0, 32'hFFFF_FF80, 4'b1000, 32'h0);
        do_req(0, 0, 0, 32'h0000_0103, 2'b00, 1, 32'h0, 32'h80FF_FFFF, 0, 32'h0000_0080, 4'b1000, 32'h0);
        do_req(0, 1, 1, 32'h0000_0202, 2'b01, 0, 32'h0000_1234, 32'h0, 0, 32'h0000_0042, 4'b1100, 32'h1234_1234);
        do_req(0, 0, 0, 32'h0000_0102, 2'b01, 0, 32'h0, 32'h8001_7FFF, 0, 32'hFFFF_8001, 4'b1100, 32'h0);
        do_req(0, 0, 0, 32'h0000_0100, 2'b01, 1, 32'h0, 32'h1234_F00D, 0, 32'h0000_F00D, 4'b0011, 32'h0);
        do_req(0, 1, 0, 32'h0000_0200, 2'b01, 0, 32'h0, 32'h0000_7FFF, 0, 32'h0000_7FFF, 4'b0011, 32'h0);
        do_req(0, 0, 1, 32'h0000_0101, 2'b00, 0, 32'h0000_00AB, 32'h0, 0, 32'h0000_F00D, 4'b0010, 32'hABAB_ABAB);
        do_req(0, 0, 1, 32'h0000_0104, 2'b10, 0, 32'hCAFE_BABE, 32'h0, 0, 32'h0000_F00D, 4'b1111, 32'hCAFE_BABE);
        do_req(0, 0, 0, 32'h0000_0101, 2'b10, 0, 32'h0, 32'h0, 1, 32'h0000_F00D, 4'b0000, 32'h0);
        do_req(0, 0, 0, 32'h0000_0100, 2'b11, 0, 32'h0, 32'h0, 1, 32'h0000_F00D, 4'b0000, 32'h0);
        do_req(0, 1, 0, 32'h0000_0203, 2'b01, 0, 32'h0, 32'h0, 1, 32'h0000_7FFF, 4'b0000, 32'h0);
        do_req(0, 1, 0, 32'h0000_0201, 2'b00, 1, 32'h0, 32'h0000_C300, 0, 32'h0000_00C3, 4'b0010, 32'h0);

        // Latency sweep plus reset-in-WAIT on every instance.
        do_req(1, 0, 0, 32'h0000_0700, 2'b10, 0, 32'h0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 4'b1111, 32'h0);
        do_req(2, 1, 1, 32'h0000_0701, 2'b00, 0, 32'h0000_005A, 32'h0, 0, 32'h0000_0000, 4'b0010, 32'h5A5A_5A5A);
        for (int g = 0; g < 3; g++) abort_in_wait(g);
        do_req(0, 0, 0, 32'h0000_0600, 2'b10, 0, 32'h0, 32'h1122_3344, 0, 32'h1122_3344, 4'b1111, 32'h0);
        do_req(1, 1, 0, 32'h0000_0602, 2'b00, 0, 32'h0, 32'h0080_0000, 0, 32'hFFFF_FF80, 4'b0100, 32'h0);
        do_req(2, 0, 0, 32'h0000_0602, 2'b01, 1, 32'h0, 32'hABCD_0000, 0, 32'h0000_ABCD, 4'b1100, 32'h0);
        do_req(2, 0, 0, 32'h0000_0606, 2'b10, 0, 32'h0, 32'h0, 1, 32'h0000_ABCD, 4'b0000, 32'h0);

        repeat (4) @(negedge clk);
        check("pending_done_expectations", exp_q.size(), 32'd0);
        check("pending_mem_expectations", mexp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
